// File: rtl/tick_bcd_display.sv
// Counts rising edges of a slow tick into a 4-digit BCD value and scans it
// onto a common-anode seven-segment display with optional leading-zero blanking.
module tick_bcd_display #(
  parameter int          SCAN_W   = 16,
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK    = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        run,
  input  logic        clear,
  output logic [15:0] count_bcd,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              tick_q;
  logic [15:0]       count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              tick_rise;
  logic [3:0]        digit;
  logic              blank_digit;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low segment patterns, dp held off.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign tick_rise = tick_in & ~tick_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = 16'h0000;
    end else if (run && tick_rise) begin
      count_d = bcd_inc(count_q);
      wrap_d  = (count_q == 16'h9999);
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // A higher digit is blanked only when it and everything above it is zero.
  always_comb begin
    digit       = 4'd0;
    blank_digit = 1'b0;
    case (idx_q)
      2'd0: digit = count_q[3:0];
      2'd1: begin
        digit       = count_q[7:4];
        blank_digit = (count_q[15:4] == 12'h000);
      end
      2'd2: begin
        digit       = count_q[11:8];
        blank_digit = (count_q[15:8] == 8'h00);
      end
      default: begin
        digit       = count_q[15:12];
        blank_digit = (count_q[15:12] == 4'h0);
      end
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = (BLANK && blank_digit) ? 8'hFF : seg_decode(digit);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tick_q  <= 1'b0;
      count_q <= 16'h0000;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
    end else begin
      tick_q  <= tick_in;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_tick_bcd_display.sv
// Bench for tick_bcd_display: integer-count reference model checked every cycle
// plus directed vectors with literal expectations.
module tb_tick_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        run = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] count_a, count_b;
  logic        wrap_a, wrap_b;
  logic [3:0]  an_a, an_b;
  logic [7:0]  seg_a, seg_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tick_bcd_display #(.SCAN_W(16), .SCAN_DIV(4), .BLANK(1'b1)) dut_a (
    .clk_in(clk), .rst(rst), .tick_in(tick_in), .run(run), .clear(clear),
    .count_bcd(count_a), .wrap(wrap_a), .an(an_a), .seg(seg_a));

  tick_bcd_display #(.SCAN_W(16), .SCAN_DIV(4), .BLANK(1'b0)) dut_b (
    .clk_in(clk), .rst(rst), .tick_in(tick_in), .run(run), .clear(clear),
    .count_bcd(count_b), .wrap(wrap_b), .an(an_b), .seg(seg_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] disp(input int n, input int k, input bit blank);
    int p;
    int d;
    logic [7:0] s;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    d = (n / p) % 10;
    case (d)
      0: s = 8'hC0; 1: s = 8'hF9; 2: s = 8'hA4; 3: s = 8'hB0; 4: s = 8'h99;
      5: s = 8'h92; 6: s = 8'h82; 7: s = 8'hF8; 8: s = 8'h80; default: s = 8'h90;
    endcase
    if (blank && k > 0 && n < p) s = 8'hFF;
    return s;
  endfunction

  // Reference model: plain integer count, cycle count since reset drives the scan.
  int         m_cnt;
  logic       m_wrap;
  logic       m_prev;
  int         m_cyc;
  logic [3:0] m_an;
  logic [7:0] m_seg_a, m_seg_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_wrap  <= 1'b0;
      m_prev  <= 1'b0;
      m_cyc   <= 0;
      m_an    <= 4'hF;
      m_seg_a <= 8'hFF;
      m_seg_b <= 8'hFF;
    end else begin
      m_an    <= ~(4'b0001 << ((m_cyc / 4) % 4));
      m_seg_a <= disp(m_cnt, (m_cyc / 4) % 4, 1'b1);
      m_seg_b <= disp(m_cnt, (m_cyc / 4) % 4, 1'b0);
      m_prev  <= tick_in;
      m_cyc   <= m_cyc + 1;
      if (clear) begin
        m_cnt  <= 0;
        m_wrap <= 1'b0;
      end else if (run && tick_in && !m_prev) begin
        m_cnt  <= (m_cnt + 1) % 10000;
        m_wrap <= (m_cnt == 9999);
      end else begin
        m_wrap <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_count_a", 32'(count_a), 32'(to_bcd(m_cnt)));
    chk("m_count_b", 32'(count_b), 32'(to_bcd(m_cnt)));
    chk("m_wrap_a", 32'(wrap_a), 32'(m_wrap));
    chk("m_wrap_b", 32'(wrap_b), 32'(m_wrap));
    chk("m_an_a", 32'(an_a), 32'(m_an));
    chk("m_an_b", 32'(an_b), 32'(m_an));
    chk("m_seg_a", 32'(seg_a), 32'(m_seg_a));
    chk("m_seg_b", 32'(seg_b), 32'(m_seg_b));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    tick_in = 1'b1;
    repeat (hi) step();
    tick_in = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] exp_sa  [4] = '{8'hF8, 8'h99, 8'hFF, 8'hFF};
  logic [7:0] exp_sb  [4] = '{8'hF8, 8'h99, 8'hC0, 8'hC0};

  initial begin
    bit         found;
    logic [3:0] prev_an;

    // Reset with tick_in toggling.
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick_in = ~tick_in;
      step();
    end
    chk("rst_count", 32'(count_a), 32'h0000);
    chk("rst_wrap", 32'(wrap_a), 32'h0);
    chk("rst_an", 32'(an_a), 32'hF);
    chk("rst_seg", 32'(seg_a), 32'hFF);
    rst = 1'b1;
    tick_in = 1'b0;
    step();
    chk("rel_an", 32'(an_a), 32'hE);
    chk("rel_seg", 32'(seg_a), 32'hC0);

    // First tick: count moves one edge after tick_in rises.
    tick_in = 1'b1;
    @(negedge clk);
    chk("lat_before", 32'(count_a), 32'h0000);
    step();
    chk("lat_after", 32'(count_a), 32'h0001);
    repeat (2) step();
    tick_in = 1'b0;
    repeat (5) step();
    repeat (11) pulse(3, 5);
    chk("count12", 32'(count_a), 32'h0012);
    pulse(20, 5);
    chk("held_high", 32'(count_a), 32'h0013);

    // Carries and wrap.
    do_clear();
    chk("clear", 32'(count_a), 32'h0000);
    repeat (99) pulse(1, 1);
    chk("c0099", 32'(count_a), 32'h0099);
    pulse(1, 1);
    chk("c0100", 32'(count_a), 32'h0100);
    repeat (899) pulse(1, 1);
    chk("c0999", 32'(count_a), 32'h0999);
    pulse(1, 1);
    chk("c1000", 32'(count_a), 32'h1000);
    repeat (8999) pulse(1, 1);
    chk("c9999", 32'(count_a), 32'h9999);
    chk("nowrap", 32'(wrap_a), 32'h0);
    tick_in = 1'b1;
    step();
    chk("wrap_count", 32'(count_a), 32'h0000);
    chk("wrap_pulse", 32'(wrap_a), 32'h1);
    tick_in = 1'b0;
    step();
    chk("wrap_one_cycle", 32'(wrap_a), 32'h0);

    // Clear beats a coincident tick; run=0 holds.
    repeat (41) pulse(1, 1);
    chk("c0041", 32'(count_a), 32'h0041);
    clear = 1'b1;
    tick_in = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_prio", 32'(count_a), 32'h0000);
    step();
    chk("clr_no_late", 32'(count_a), 32'h0000);
    tick_in = 1'b0;
    step();
    repeat (3) pulse(1, 1);
    chk("c0003", 32'(count_a), 32'h0003);
    run = 1'b0;
    repeat (5) pulse(2, 2);
    chk("run_hold", 32'(count_a), 32'h0003);
    run = 1'b1;

    // Scan and blanking at 0047.
    do_clear();
    repeat (47) pulse(1, 1);
    chk("c0047", 32'(count_a), 32'h0047);
    found = 1'b0;
    @(negedge clk);
    prev_an = an_a;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev_an == 4'h7 && an_a == 4'hE) found = 1'b1;
      else prev_an = an_a;
    end
    chk("scan_sync", 32'(found), 32'h1);
    if (found) begin
      for (int j = 0; j < 16; j++) begin
        chk("scan_an", 32'(an_a), 32'(exp_an[j/4]));
        chk("scan_seg_blank", 32'(seg_a), 32'(exp_sa[j/4]));
        chk("scan_seg_noblank", 32'(seg_b), 32'(exp_sb[j/4]));
        @(negedge clk);
      end
    end
    step();

    // Asynchronous reset mid-count.
    do_clear();
    repeat (573) pulse(1, 1);
    chk("c0573", 32'(count_a), 32'h0573);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count_a), 32'h0000);
    chk("arst_wrap", 32'(wrap_a), 32'h0);
    chk("arst_an", 32'(an_a), 32'hF);
    chk("arst_seg", 32'(seg_a), 32'hFF);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("arst_rel_an", 32'(an_a), 32'hE);
    chk("arst_rel_seg", 32'(seg_a), 32'hC0);
    repeat (2) pulse(1, 1);
    chk("restart", 32'(count_a), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_bcd_display.md
Name: tick_bcd_display

Overview:
Downstream consumer of the divided slow clock. Counts rising edges of the slow clock (tick_in, a registered signal in the clk_in domain) into a 4-digit BCD value, 0000-9999. Multiplexes that value onto a common-anode 4-digit seven-segment display with optional leading-zero blanking. Gives the board a visible seconds/event counter driven by the divider.

Parameters:
SCAN_W, 16, width of the scan prescaler counter.
SCAN_DIV, 16'd50000, clk_in cycles each digit stays lit; range 1..2^SCAN_W.
BLANK, 1'b1, 1 = blank leading zeros (digit 0 always shown); 0 = show all digits.

Ports:
clk_in  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
tick_in  input  1  divided slow clock, synchronous to clk_in; counted on its rising edge.
run  input  1  1 = count ticks; 0 = hold count.
clear  input  1  synchronous clear of the count; level-sensitive.
count_bcd  output  16  current count; [3:0] = ones ... [15:12] = thousands.
wrap  output  1  one-cycle pulse when the count rolls 9999 -> 0000.
an  output  4  digit enables, active-low; an[0] = ones digit.
seg  output  8  segments, active-low; [7] = dp, [6:0] = g..a.

Behaviour:
- Reset (rst=0, asynchronous) sets: tick_q=0, count_bcd=0, wrap=0, digit index=0, scan counter=0, an=4'b1111, seg=8'hFF. Same result when asserted mid-operation; operation resumes on the first clk_in edge after release.
- Edge detect: tick_q <= tick_in every cycle, including while run=0 or clear=1. tick_rise = tick_in & ~tick_q.
- Count update, per clk_in edge, in priority order:
  - clear=1: count_bcd <= 0, wrap <= 0. A coincident tick_rise is discarded.
  - else run & tick_rise: BCD increment with decimal carry through all digits.
    - 9999 -> 0000 with wrap <= 1.
    - Otherwise wrap <= 0.
  - else hold count, wrap <= 0.
- Latency: count_bcd changes on the first clk_in edge at which tick_in=1 and tick_q=0, i.e. one cycle after tick_in rises. A tick_in high for many cycles counts once.
- BCD digits never hold values above 9.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 continuously, independent of run and clear.
  - When it wraps, digit index advances 0->1->2->3->0.
  - SCAN_DIV=1 advances the index every cycle.
- Display outputs are registered and updated every cycle from the current index and count_bcd. an/seg lag the index by one cycle.
  - an = all ones except bit[index] = 0.
- Decode, dp always 1: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
- Blanking (BLANK=1): digit k>0 shows seg=FF when it and all higher digits are zero. an still enables it. Digit 0 is never blanked.
- No other outputs exist. No handshake; a tick is lost only when clear is high or run is low.

Test Plan:
- Reset: hold rst=0 with tick_in toggling -> count_bcd=0000, wrap=0, an=1111, seg=FF; 1 cycle after release, an=1110, seg=C0.
- Counting: run=1, 12 tick_in pulses, each 3 cycles high and 5 low -> count_bcd=0012; each increment exactly 1 cycle after the tick_in rise. tick_in held high 20 cycles -> +1 only.
- Carry/wrap: clear, then 9999 ticks -> 9999. Next tick -> 0000 with wrap=1 for exactly 1 cycle. Also check 0099 -> 0100 and 0999 -> 1000.
- Priority: clear=1 in the same cycle as tick_rise at count 0041 -> 0000, no increment. run=0 with 5 ticks -> count unchanged.
- Scan and blanking: SCAN_DIV=4, count 0047, BLANK=1.
  - an cycles 1110, 1101, 1011, 0111, 4 cycles each.
  - seg sequence: 0x F8, 99, FF, FF (digit 0 = 7, digit 1 = 4, digits 2-3 blanked).
  - BLANK=0 -> digits 2-3 show C0.
- Reset mid-count: assert rst at count 0573 between clock edges -> outputs reach reset values immediately, without a clock edge. Counting restarts from 0000.
